// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register-file family (param_regfile, ARF successor).
package regfile_pkg;

    typedef enum logic [1:0] {
        FS_DEC   = 2'b00,
        FS_INC   = 2'b01,
        FS_LOAD  = 2'b10,
        FS_CLEAR = 2'b11
    } funsel_e;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;
    localparam int unsigned NREG_MIN  = 2;
    localparam int unsigned NREG_MAX  = 16;

endpackage

// File: rtl/regfile_cell.sv
// One counter-capable register with its sticky wrap/saturate flag.
module regfile_cell
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic [1:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Q,
    output logic             wrap
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_min;

    assign at_max = (q_q == '1);
    assign at_min = (q_q == '0);

    always_comb begin
        q_d    = q_q;
        wrap_d = wrap_q;
        if (en) begin
            case (funsel_e'(FunSel))
                FS_DEC: begin
                    // The boundary sets the flag in both modes; only the value update differs.
                    if (at_min) wrap_d = 1'b1;
                    if (!(SATURATE != 0 && at_min)) q_d = q_q - WIDTH'(1);
                end
                FS_INC: begin
                    if (at_max) wrap_d = 1'b1;
                    if (!(SATURATE != 0 && at_max)) q_d = q_q + WIDTH'(1);
                end
                FS_LOAD: begin
                    q_d    = I;
                    wrap_d = 1'b0;
                end
                FS_CLEAR: begin
                    q_d    = '0;
                    wrap_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/param_regfile.sv
// NREG x WIDTH register file with shared function select, multi-hot write mask and two read ports.
module param_regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NREG     = 4,
    parameter int SATURATE = 0,
    parameter int SELW     = $clog2(NREG)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              En,
    input  logic [1:0]        FunSel,
    input  logic [NREG-1:0]   RegSel,
    input  logic [WIDTH-1:0]  I,
    input  logic [SELW-1:0]   OutASel,
    input  logic [SELW-1:0]   OutBSel,
    output logic [WIDTH-1:0]  OutA,
    output logic [WIDTH-1:0]  OutB,
    output logic [NREG-1:0]   Wrap
);

    logic [WIDTH-1:0] regs [NREG];

    for (genvar k = 0; k < NREG; k++) begin : g_cell
        regfile_cell #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_cell (
            .CLK    (CLK),
            .RST    (RST),
            .en     (En & RegSel[k]),
            .FunSel (FunSel),
            .I      (I),
            .Q      (regs[k]),
            .wrap   (Wrap[k])
        );
    end

    // Indices past NREG match no register, so the port reads zero.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int unsigned k = 0; k < NREG; k++) begin
            if (OutASel == SELW'(k)) OutA = regs[k];
            if (OutBSel == SELW'(k)) OutB = regs[k];
        end
    end

endmodule
